// File: rtl/ll1_stim_seq.sv
// Exhaustive stimulus sequencer for the 3-input ll1 block: sweeps all 8 vectors,
// samples f_in at the end of each hold window and checks the captured truth table.
module ll1_stim_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter bit          GRAY        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  input  logic [7:0] expected,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       tt_valid,
  output logic       match
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] vec_cur;
  logic [IDX_W-1:0] vec_nxt;
  logic [7:0]       tt_upd;

  // Sweep index to driven vector (binary or reflected Gray order)
  function automatic logic [IDX_W-1:0] vec_of(input logic [IDX_W-1:0] i);
    if (GRAY) return i ^ (i >> 1);
    return i;
  endfunction

  // Current/next vector and the truth table including the sample taken this cycle
  always_comb begin
    vec_cur         = vec_of(idx);
    vec_nxt         = vec_of(IDX_W'(idx + IDX_W'(1)));
    tt_upd          = tt;
    tt_upd[vec_cur] = f_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      idx                     <= '0;
      hold_cnt                <= '0;
      {a_out, b_out, c_out}   <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      tt                      <= 8'h00;
      tt_valid                <= 1'b0;
      match                   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          {a_out, b_out, c_out} <= '0;
          if (start) begin
            state                 <= DRIVE;
            idx                   <= '0;
            hold_cnt              <= '0;
            tt                    <= 8'h00;
            tt_valid              <= 1'b0;
            match                 <= 1'b0;
            busy                  <= 1'b1;
            {a_out, b_out, c_out} <= vec_of('0);
          end
        end
        DRIVE: begin
          hold_cnt <= CNT_W'(hold_cnt + CNT_W'(1));
          // End of hold window: capture f_in and advance or finish
          if (hold_cnt == HOLD_LAST) begin
            tt <= tt_upd;
            if (idx == IDX_LAST) begin
              state                 <= DONE;
              done                  <= 1'b1;
              busy                  <= 1'b0;
              tt_valid              <= 1'b1;
              match                 <= (tt_upd == expected);
              {a_out, b_out, c_out} <= '0;
            end else begin
              idx                   <= IDX_W'(idx + IDX_W'(1));
              hold_cnt              <= '0;
              {a_out, b_out, c_out} <= vec_nxt;
            end
          end
        end
        DONE: begin
          state                 <= IDLE;
          {a_out, b_out, c_out} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ll1_stim_seq.sv
// Scoreboard bench for ll1_stim_seq: a binary-order instance (HOLD=4, f=A^C)
// and a Gray-order instance (HOLD=1, f=A&B&C), each with a behavioural ll1 model.
module tb_ll1_stim_seq;

  typedef struct {
    logic [7:0] tt;
    logic       m;
    int         cyc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_s [2];
  logic       f_s     [2];
  logic [7:0] exp_s   [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       c_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] tt_s    [2];
  logic       ttv_s   [2];
  logic       match_s [2];

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  sb_t q0[$];
  sb_t q1[$];

  localparam logic [2:0] GRAY_SEQ [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  localparam int HOLD [2] = '{4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_s[0] = a_s[0] ^ c_s[0];
  assign f_s[1] = a_s[1] & b_s[1] & c_s[1];

  ll1_stim_seq #(.HOLD_CYCLES(4), .GRAY(1'b0)) u_bin (
    .clk(clk), .rst(rst), .start(start_s[0]), .f_in(f_s[0]), .expected(exp_s[0]),
    .a_out(a_s[0]), .b_out(b_s[0]), .c_out(c_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .tt(tt_s[0]), .tt_valid(ttv_s[0]), .match(match_s[0])
  );

  ll1_stim_seq #(.HOLD_CYCLES(1), .GRAY(1'b1)) u_gray (
    .clk(clk), .rst(rst), .start(start_s[1]), .f_in(f_s[1]), .expected(exp_s[1]),
    .a_out(a_s[1]), .b_out(b_s[1]), .c_out(c_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .tt(tt_s[1]), .tt_valid(ttv_s[1]), .match(match_s[1])
  );

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  function automatic int all_outs(input int d);
    return int'({a_s[d], b_s[d], c_s[d], busy_s[d], done_s[d], ttv_s[d], match_s[d], tt_s[d]});
  endfunction

  function automatic int vec(input int d);
    return int'({a_s[d], b_s[d], c_s[d]});
  endfunction

  task automatic check_done(input int d, input sb_t it);
    chk($sformatf("done_cyc%0d", d), cyc, it.cyc);
    chk($sformatf("tt%0d", d), int'(tt_s[d]), int'(it.tt));
    chk($sformatf("match%0d", d), int'(match_s[d]), int'(it.m));
    chk($sformatf("tt_valid%0d", d), int'(ttv_s[d]), 1);
  endtask

  // Monitors: pop an expectation whenever a done pulse is seen
  always @(negedge clk) begin
    if (done_s[0] === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_done0", 1, 0);
      else check_done(0, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done_s[1] === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else check_done(1, q1.pop_front());
    end
  end

  // Full sweep starting at the current negedge; returns at the negedge of the DONE cycle
  task automatic run_sweep(input int d, input logic [7:0] exp_tt, input logic [7:0] ref_tt,
                           input bit poke);
    sb_t it;
    int  h = HOLD[d];
    int  want;
    it.tt  = exp_tt;
    it.m   = (exp_tt == ref_tt);
    it.cyc = cyc + 1 + 8 * h;
    if (d == 0) q0.push_back(it); else q1.push_back(it);
    exp_s[d]   = ref_tt;
    start_s[d] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < h; j++) begin
        @(negedge clk);
        start_s[d] = poke && (k == 3) && (j == 0);
        want = (d == 0) ? k : int'(GRAY_SEQ[k]);
        chk($sformatf("vec%0d_k%0d", d, k), vec(d), want);
        chk($sformatf("busy%0d", d), int'(busy_s[d]), 1);
        if (k == 0 && j == 0) chk($sformatf("tt_valid_clr%0d", d), int'(ttv_s[d]), 0);
      end
    end
    start_s[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("done_vec%0d", d), vec(d), 0);
    chk($sformatf("done_busy%0d", d), int'(busy_s[d]), 0);
  endtask

  task automatic idle_check(input int d, input logic [7:0] exp_tt, input logic m);
    @(negedge clk);
    chk($sformatf("idle_done%0d", d), int'(done_s[d]), 0);
    chk($sformatf("idle_busy%0d", d), int'(busy_s[d]), 0);
    chk($sformatf("idle_vec%0d", d), vec(d), 0);
    chk($sformatf("idle_hold%0d", d), int'({ttv_s[d], match_s[d], tt_s[d]}), int'({1'b1, m, exp_tt}));
  endtask

  initial begin
    start_s = '{1'b1, 1'b1};
    exp_s   = '{8'h00, 8'h00};
    rst     = 1'b1;
    // Reset held with start high: everything stays at zero
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs0", all_outs(0), 0);
      chk("rst_outs1", all_outs(1), 0);
    end
    rst        = 1'b0;
    start_s[1] = 1'b0;

    // Binary sweep launched by the still-high start right after reset release
    run_sweep(0, 8'h5A, 8'h5A, 1'b0);
    idle_check(0, 8'h5A, 1'b1);
    // Immediate restart on first IDLE edge, mismatching reference, mid-sweep start pulse
    run_sweep(0, 8'h5A, 8'h5B, 1'b1);
    idle_check(0, 8'h5A, 1'b0);
    run_sweep(0, 8'h5A, 8'h5A, 1'b1);
    idle_check(0, 8'h5A, 1'b1);

    // Gray order, one cycle per vector
    run_sweep(1, 8'h80, 8'h80, 1'b0);
    idle_check(1, 8'h80, 1'b1);
    run_sweep(1, 8'h80, 8'h7F, 1'b0);
    idle_check(1, 8'h80, 1'b0);

    // Reset during vector 5 of a binary sweep: no done, partial table discarded
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (5 * 4 + 1) @(negedge clk);
    chk("pre_rst_vec", vec(0), 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", all_outs(0), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_outs", all_outs(0), 0);

    run_sweep(0, 8'h5A, 8'h5A, 1'b0);
    idle_check(0, 8'h5A, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: got cycle %0d, want completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
